// File: rtl/alu_bist_if.sv
// Signal bundle between the BIST driver and the lab ALU/control side.
// master = BIST driver, slave = ALU plus whoever issues start.
interface alu_bist_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_operation;
    logic [31:0] res;
    logic        zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;

    modport master (
        input  start, res, zero,
        output A, B, ALU_operation, busy, done, pass, signature
    );

    modport slave (
        output start, res, zero,
        input  A, B, ALU_operation, busy, done, pass, signature
    );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test: LFSR operand pairs, all ten opcodes per pair,
// MISR compression of res/zero, pass/fail against a golden signature.
module alu_bist #(
    parameter int unsigned PATTERNS = 64,
    parameter int unsigned SETTLE   = 1,
    parameter logic [31:0] SEED_A   = 32'hA5A5A5A5,
    parameter logic [31:0] SEED_B   = 32'h5A5A5A5A,
    parameter logic [31:0] GOLDEN   = 32'h00000000
) (
    input logic         clk,
    input logic         rst_n,
    alu_bist_if.master  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] LFSR_POLY   = 32'h80200003;
    localparam logic [31:0] MISR_POLY   = 32'h04C11DB7;
    localparam logic [31:0] SEED_A_EFF  = (SEED_A == '0) ? 32'h00000001 : SEED_A;
    localparam logic [31:0] SEED_B_EFF  = (SEED_B == '0) ? 32'h00000001 : SEED_B;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] PAT_LAST    = 32'(PATTERNS - 1);
    localparam logic [3:0]  OP_LAST     = 4'd9;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] r,
                                              input logic        z);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : '0) ^ r ^ {31'b0, z};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] pat_q, pat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] sig_cap;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sig_d    = sig_q;
        settle_d = settle_q;
        pat_d    = pat_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        sig_cap  = misr_step(sig_q, bus.res, bus.zero);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    a_d      = SEED_A_EFF;
                    b_d      = SEED_B_EFF;
                    op_d     = '0;
                    sig_d    = '0;
                    settle_d = '0;
                    pat_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    sig_d    = sig_cap;
                    if (op_q == OP_LAST) begin
                        // Last pattern: operands are frozen, not stepped, on entry to DONE.
                        if (pat_q == PAT_LAST) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (sig_cap == GOLDEN);
                        end else begin
                            op_d  = '0;
                            a_d   = lfsr_step(a_q);
                            b_d   = lfsr_step(b_q);
                            pat_d = pat_q + 32'd1;
                        end
                    end else begin
                        op_d = op_q + 4'd1;
                    end
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sig_q    <= '0;
            settle_q <= '0;
            pat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sig_q    <= sig_d;
            settle_q <= settle_d;
            pat_q    <= pat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.A             = a_q;
    assign bus.B             = b_q;
    assign bus.ALU_operation = op_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.signature     = sig_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: scoreboarded runs against a real ALU model, plus
// directed checks on small stub-ALU configurations.
module tb_alu_bist;

    localparam int unsigned M_P    = 2;
    localparam int unsigned M_S    = 3;
    localparam logic [31:0] M_SA   = 32'hA5A5A5A5;
    localparam logic [31:0] M_SB   = 32'h5A5A5A5A;
    localparam logic [31:0] M_GOLD = 32'h00000000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] sig;
        logic        pass;
    } fin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_s = 1'b0;
    always #5 clk = ~clk;

    alu_bist_if bus_m();
    alu_bist_if bus_s1();
    alu_bist_if bus_s0();
    alu_bist_if bus_z();

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    vec_t        vq[$];
    fin_t        fq[$];
    logic [31:0] last_sig = '0;

    // Lab ALU opcode map: and, or, add, xor, nor, srl, sub, slt, sll, sra.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return ~(a | b);
            4'd5: return a >> b[4:0];
            4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return a << b[4:0];
            4'd9: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        logic [31:0] t;
        t = x >> 1;
        if (x[0]) t = t ^ 32'h80200003;
        return t;
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] r,
                                              input logic z);
        logic [31:0] t;
        t = s << 1;
        if (s[31]) t = t ^ 32'h04C11DB7;
        return t ^ r ^ {31'b0, z};
    endfunction

    assign bus_m.res  = alu_f(bus_m.A, bus_m.B, bus_m.ALU_operation);
    assign bus_m.zero = (bus_m.res == 32'd0);
    assign bus_s1.res = 32'h1;
    assign bus_s1.zero = 1'b0;
    assign bus_s0.res = 32'h1;
    assign bus_s0.zero = 1'b0;
    assign bus_z.res  = 32'h1;
    assign bus_z.zero = 1'b0;
    assign bus_s1.start = start_s;
    assign bus_s0.start = start_s;
    assign bus_z.start  = start_s;

    alu_bist #(.PATTERNS(M_P), .SETTLE(M_S), .SEED_A(M_SA), .SEED_B(M_SB), .GOLDEN(M_GOLD))
        u_main (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    alu_bist #(.PATTERNS(1), .SETTLE(1), .GOLDEN(32'h000003FF))
        u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));
    alu_bist #(.PATTERNS(1), .SETTLE(1), .GOLDEN(32'h00000000))
        u_s0 (.clk(clk), .rst_n(rst_n), .bus(bus_s0));
    alu_bist #(.PATTERNS(1), .SETTLE(1), .SEED_A(32'h00000000))
        u_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got A=%08h B=%08h op=%0d expected A=%08h B=%08h op=%0d",
                      name, act.a, act.b, act.op, exp.a, exp.b, exp.op);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: condition not met", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected run from plain loops over patterns and opcodes.
    task automatic push_run();
        logic [31:0] a, b, sig, r;
        fin_t f;
        a = M_SA;
        b = M_SB;
        sig = '0;
        for (int unsigned p = 0; p < M_P; p++) begin
            for (int unsigned op = 0; op < 10; op++) begin
                for (int unsigned s = 0; s < M_S; s++) vq.push_back('{a, b, 4'(op)});
                r = alu_f(a, b, 4'(op));
                sig = misr_next(sig, r, r == 32'd0);
            end
            if (p != M_P - 1) begin
                a = lfsr_next(a);
                b = lfsr_next(b);
            end
        end
        f = '{a, b, 4'd9, sig, sig == M_GOLD};
        fq.push_back(f);
        last_sig = sig;
    endtask

    task automatic start_run();
        bus_m.start = 1'b1;
        push_run();
        tick();
        bus_m.start = 1'b0;
        chk("start_sig_cleared", bus_m.signature, 32'd0);
        chk("start_busy", 32'(bus_m.busy), 32'd1);
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned i = 0;
        while (!bus_m.done && i < budget) begin
            tick();
            i++;
        end
        if (!bus_m.done) fail_now("done_timeout");
    endtask

    // Monitor: pops one vector per busy cycle, one final record per done rise.
    initial begin
        vec_t v;
        fin_t f;
        int unsigned busy_cnt = 0;
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_m.busy) begin
                busy_cnt++;
                if (vq.size() == 0) fail_now("unexpected_busy");
                else begin
                    v = vq.pop_front();
                    chk_vec("vector", '{bus_m.A, bus_m.B, bus_m.ALU_operation}, v);
                end
            end else begin
                if (bus_m.done && !done_prev) begin
                    if (fq.size() == 0) fail_now("unexpected_done");
                    else begin
                        f = fq.pop_front();
                        chk("final_sig", bus_m.signature, f.sig);
                        chk("final_pass", 32'(bus_m.pass), 32'(f.pass));
                        chk_vec("final_hold_vec", '{bus_m.A, bus_m.B, bus_m.ALU_operation},
                                '{f.a, f.b, f.op});
                        chk("run_length", busy_cnt, 10 * M_P * M_S);
                    end
                end
                busy_cnt = 0;
            end
            done_prev = bus_m.done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_m.start = 1'b1;
        start_s = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_A", bus_m.A, 32'd0);
        chk("rst_B", bus_m.B, 32'd0);
        chk("rst_flags", {24'd0, bus_m.ALU_operation, bus_m.busy, bus_m.done, bus_m.pass, 1'b0}, 32'd0);
        chk("rst_sig", bus_m.signature, 32'd0);
        chk("rst_stub_busy", 32'(bus_s1.busy), 32'd0);
        bus_m.start = 1'b0;
        start_s = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_rst", {30'd0, bus_m.busy, bus_m.done}, 32'd0);

        // Stub ALU: ten single-cycle captures of res=1, zero=0.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            chk("stub_busy", 32'(bus_s1.busy), 32'd1);
            chk("stub_op", 32'(bus_s1.ALU_operation), k);
            chk("stub_A", bus_s1.A, 32'hA5A5A5A5);
            chk("stub_B", bus_s1.B, 32'h5A5A5A5A);
            chk("zseed_A", bus_z.A, 32'h00000001);
            tick();
        end
        chk("stub_busy_end", {30'd0, bus_s1.busy, bus_s1.done}, 32'd1);
        chk("stub_sig", bus_s1.signature, 32'h000003FF);
        chk("stub_pass_gold3ff", 32'(bus_s1.pass), 32'd1);
        chk("stub_pass_gold0", 32'(bus_s0.pass), 32'd0);
        chk("stub0_sig", bus_s0.signature, 32'h000003FF);
        chk("zseed_done", 32'(bus_z.done), 32'd1);

        // Real ALU, first run.
        repeat ($urandom_range(1, 4)) tick();
        start_run();
        wait_done(200);
        repeat (4) tick();
        chk("done_hold_sig", bus_m.signature, last_sig);
        chk("done_hold_flags", {28'd0, bus_m.ALU_operation}, 32'd9);
        chk("done_hold_done", 32'(bus_m.done), 32'd1);

        // Restart from DONE with stray start pulses mid-run.
        start_run();
        repeat ($urandom_range(3, 20)) tick();
        bus_m.start = 1'b1;
        tick();
        bus_m.start = 1'b0;
        repeat ($urandom_range(1, 15)) tick();
        bus_m.start = 1'b1;
        tick();
        bus_m.start = 1'b0;
        wait_done(200);
        repeat ($urandom_range(1, 4)) tick();

        // Reset during op 0101 of pattern 0 abandons the run.
        start_run();
        repeat (15) tick();
        chk("abort_op", 32'(bus_m.ALU_operation), 32'd5);
        rst_n = 1'b0;
        tick();
        vq.delete();
        fq.delete();
        chk("abort_A", bus_m.A, 32'd0);
        chk("abort_B", bus_m.B, 32'd0);
        chk("abort_flags", {24'd0, bus_m.ALU_operation, bus_m.busy, bus_m.done, bus_m.pass, 1'b0}, 32'd0);
        chk("abort_sig", bus_m.signature, 32'd0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        chk("abort_idle", {30'd0, bus_m.busy, bus_m.done}, 32'd0);
        start_run();
        wait_done(200);
        repeat (3) tick();

        chk("queue_drain", 32'(vq.size() + fq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
